// File: rtl/status_stack_reg_pkg.sv
// Shared flag layout, default sizes and stack operation encoding for the status stack register.
package status_stack_reg_pkg;

   localparam int FLAG_Z     = 0;
   localparam int FLAG_C     = 1;
   localparam int FLAG_N     = 2;
   localparam int FLAG_V     = 3;

   localparam int DEF_FLAG_W = 4;
   localparam int DEF_DEPTH  = 4;

   // Encoded as {push, pop} so the strobes map directly onto an operation.
   typedef enum logic [1:0] {
      OP_NONE = 2'b00,
      OP_POP  = 2'b01,
      OP_PUSH = 2'b10,
      OP_SWAP = 2'b11
   } stack_op_e;

endpackage

// File: rtl/status_stack_reg_if.sv
// Flag/stack control bundle between the control unit (master) and the status stack register (slave).
interface status_stack_reg_if
   import status_stack_reg_pkg::*;
#(
   parameter int FLAG_W = DEF_FLAG_W,
   parameter int DEPTH  = DEF_DEPTH
);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic              notLoad;
   logic [FLAG_W-1:0] loadMask;
   logic [FLAG_W-1:0] flagsIn;
   logic [FLAG_W-1:0] flagsOut;
   logic              push;
   logic              pop;
   logic              errClear;
   logic [CNT_W-1:0]  count;
   logic              full;
   logic              empty;
   logic              overflowErr;
   logic              underflowErr;

   modport master (
      output notLoad, loadMask, flagsIn, push, pop, errClear,
      input  flagsOut, count, full, empty, overflowErr, underflowErr
   );

   modport slave (
      input  notLoad, loadMask, flagsIn, push, pop, errClear,
      output flagsOut, count, full, empty, overflowErr, underflowErr
   );

endinterface

// File: rtl/status_stack_reg_mem.sv
// DEPTH x FLAG_W flag save array: one write port, one unregistered read of the addressed entry.
// Contents are not reset; only entries below the live count are ever read meaningfully.
module flag_stack_mem #(
   parameter int FLAG_W = 4,
   parameter int DEPTH  = 4,
   parameter int PTR_W  = 2
) (
   input  logic              i_clock,
   input  logic              i_we,
   input  logic [PTR_W-1:0]  i_waddr,
   input  logic [FLAG_W-1:0] i_wdat,
   input  logic [PTR_W-1:0]  i_raddr,
   output logic [FLAG_W-1:0] o_rdat
);

   logic [FLAG_W-1:0] r_mem [DEPTH];

   always_ff @(posedge i_clock) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdat;
      end
   end

   assign o_rdat = r_mem[i_raddr];

endmodule

// File: rtl/status_stack_reg.sv
// Condition-flag register with per-flag load and a LIFO save/restore stack with sticky over/underflow.
// All outputs registered (or compares of registered count); one-cycle effect latency, no backpressure.
module status_stack_reg
   import status_stack_reg_pkg::*;
#(
   parameter int FLAG_W = DEF_FLAG_W,
   parameter int DEPTH  = DEF_DEPTH
) (
   input  logic                i_clock,
   input  logic                i_reset,
   status_stack_reg_if.slave   bus
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [FLAG_W-1:0] r_flags;
   logic [CNT_W-1:0]  r_count;
   logic              r_ovf;
   logic              r_udf;

   logic              w_empty;
   logic              w_full;
   stack_op_e         w_op;
   logic [FLAG_W-1:0] w_load_val;
   logic [FLAG_W-1:0] w_top;
   logic [PTR_W-1:0]  w_top_idx;
   logic              w_we;
   logic [PTR_W-1:0]  w_waddr;
   logic [FLAG_W-1:0] w_nxt_flags;
   logic [CNT_W-1:0]  w_nxt_count;
   logic              w_ovf_ev;
   logic              w_udf_ev;

   assign w_empty    = (r_count == '0);
   assign w_full     = (r_count == CNT_W'(DEPTH));
   assign w_op       = stack_op_e'({bus.push, bus.pop});
   assign w_load_val = bus.notLoad ? r_flags
                                   : ((r_flags & ~bus.loadMask) | (bus.flagsIn & bus.loadMask));
   assign w_top_idx  = w_empty ? '0 : PTR_W'(r_count - CNT_W'(1));

   flag_stack_mem #(
      .FLAG_W (FLAG_W),
      .DEPTH  (DEPTH),
      .PTR_W  (PTR_W)
   ) u_mem (
      .i_clock (i_clock),
      .i_we    (w_we),
      .i_waddr (w_waddr),
      .i_wdat  (r_flags),
      .i_raddr (w_top_idx),
      .o_rdat  (w_top)
   );

   // A successful pop or swap restores flags and suppresses the load; every other case lets the load through.
   always_comb begin
      w_we        = 1'b0;
      w_waddr     = PTR_W'(r_count);
      w_nxt_flags = w_load_val;
      w_nxt_count = r_count;
      w_ovf_ev    = 1'b0;
      w_udf_ev    = 1'b0;
      unique case (w_op)
         OP_PUSH: begin
            if (w_full) begin
               w_ovf_ev = 1'b1;
            end else begin
               w_we        = 1'b1;
               w_nxt_count = r_count + CNT_W'(1);
            end
         end
         OP_POP: begin
            if (w_empty) begin
               w_udf_ev = 1'b1;
            end else begin
               w_nxt_flags = w_top;
               w_nxt_count = r_count - CNT_W'(1);
            end
         end
         OP_SWAP: begin
            w_we = 1'b1;
            if (w_empty) begin
               w_udf_ev    = 1'b1;
               w_waddr     = '0;
               w_nxt_count = CNT_W'(1);
            end else begin
               w_waddr     = w_top_idx;
               w_nxt_flags = w_top;
            end
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_flags <= '0;
         r_count <= '0;
         r_ovf   <= 1'b0;
         r_udf   <= 1'b0;
      end else begin
         r_flags <= w_nxt_flags;
         r_count <= w_nxt_count;
         r_ovf   <= (r_ovf & ~bus.errClear) | w_ovf_ev;
         r_udf   <= (r_udf & ~bus.errClear) | w_udf_ev;
      end
   end

   assign bus.flagsOut     = r_flags;
   assign bus.count        = r_count;
   assign bus.full         = w_full;
   assign bus.empty        = w_empty;
   assign bus.overflowErr  = r_ovf;
   assign bus.underflowErr = r_udf;

endmodule

// File: tb/tb_status_stack_reg.sv
// Self-checking bench for status_stack_reg: directed scenarios plus randomized traffic against a queue model.
module tb_status_stack_reg;
   import status_stack_reg_pkg::*;

   localparam int FW = 4;
   localparam int DP = 4;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   // Reference model: live flags, a queue as the stack, sticky error bits.
   logic [FW-1:0] m_flags;
   logic [FW-1:0] m_stack[$];
   logic          m_ovf;
   logic          m_udf;

   status_stack_reg_if #(.FLAG_W(FW), .DEPTH(DP)) bus ();

   status_stack_reg #(.FLAG_W(FW), .DEPTH(DP)) dut (
      .i_clock (clk),
      .i_reset (rst),
      .bus     (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_step(input logic r, input logic nl, input logic [FW-1:0] m,
                             input logic [FW-1:0] f, input logic ps, input logic pp, input logic ec);
      logic [FW-1:0] loaded;
      logic [FW-1:0] tmp;
      logic ov, un;
      if (r) begin
         m_flags = '0;
         m_stack.delete();
         m_ovf = 1'b0;
         m_udf = 1'b0;
         return;
      end
      loaded = nl ? m_flags : ((m_flags & ~m) | (f & m));
      ov = 1'b0;
      un = 1'b0;
      if (ps && !pp) begin
         if (m_stack.size() < DP) m_stack.push_back(m_flags);
         else ov = 1'b1;
         m_flags = loaded;
      end else if (pp && !ps) begin
         if (m_stack.size() > 0) m_flags = m_stack.pop_back();
         else begin
            un = 1'b1;
            m_flags = loaded;
         end
      end else if (pp && ps) begin
         if (m_stack.size() > 0) begin
            tmp = m_stack[m_stack.size()-1];
            m_stack[m_stack.size()-1] = m_flags;
            m_flags = tmp;
         end else begin
            un = 1'b1;
            m_stack.push_back(m_flags);
            m_flags = loaded;
         end
      end else begin
         m_flags = loaded;
      end
      m_ovf = (m_ovf & ~ec) | ov;
      m_udf = (m_udf & ~ec) | un;
   endtask

   task automatic tick(input logic r, input logic nl, input logic [FW-1:0] m,
                       input logic [FW-1:0] f, input logic ps, input logic pp, input logic ec);
      rst          = r;
      bus.notLoad  = nl;
      bus.loadMask = m;
      bus.flagsIn  = f;
      bus.push     = ps;
      bus.pop      = pp;
      bus.errClear = ec;
      model_step(r, nl, m, f, ps, pp, ec);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      tick(1, 1, 4'h0, 4'h0, 0, 0, 0);
      checks++; if (bus.flagsOut !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b want 0000", bus.flagsOut); end
      checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", bus.count); end
      checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", bus.empty); end
      checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", bus.full); end
      checks++; if (bus.overflowErr !== 1'b0 || bus.underflowErr !== 1'b0)
         begin errors++; $display("FAIL reset_errs got %b%b want 00", bus.overflowErr, bus.underflowErr); end
   endtask

   task automatic test_load_mask();
      tick(1, 1, 4'h0, 4'h0, 0, 0, 0);
      tick(0, 0, 4'b0011, 4'b1110, 0, 0, 0);
      checks++; if (bus.flagsOut !== 4'b0010) begin errors++; $display("FAIL load_mask got %b want 0010", bus.flagsOut); end
      checks++; if (bus.count !== 3'd0 || bus.empty !== 1'b1)
         begin errors++; $display("FAIL load_mask_cnt got %0d/%b want 0/1", bus.count, bus.empty); end
      tick(0, 1, 4'b1111, 4'b1111, 0, 0, 0);
      checks++; if (bus.flagsOut !== 4'b0010) begin errors++; $display("FAIL load_disabled got %b want 0010", bus.flagsOut); end
   endtask

   task automatic test_push_pop();
      tick(1, 1, 4'h0, 4'h0, 0, 0, 0);
      tick(0, 0, 4'b1111, 4'b0101, 0, 0, 0);
      tick(0, 1, 4'h0, 4'h0, 1, 0, 0);
      tick(0, 0, 4'b1111, 4'b1010, 0, 0, 0);
      checks++; if (bus.flagsOut !== 4'b1010 || bus.count !== 3'd1)
         begin errors++; $display("FAIL pushed got %b/%0d want 1010/1", bus.flagsOut, bus.count); end
      tick(0, 1, 4'h0, 4'h0, 0, 1, 0);
      checks++; if (bus.flagsOut !== 4'b0101 || bus.count !== 3'd0)
         begin errors++; $display("FAIL popped got %b/%0d want 0101/0", bus.flagsOut, bus.count); end
      tick(0, 1, 4'h0, 4'h0, 1, 0, 0);
      tick(0, 0, 4'b1111, 4'b1111, 0, 1, 0);
      checks++; if (bus.flagsOut !== 4'b0101) begin errors++; $display("FAIL pop_ignores_load got %b want 0101", bus.flagsOut); end
   endtask

   task automatic test_overflow();
      tick(1, 1, 4'h0, 4'h0, 0, 0, 0);
      tick(0, 0, 4'b1111, 4'b0001, 0, 0, 0);
      for (int k = 0; k < 5; k++) begin
         tick(0, 0, 4'b1111, 4'(k + 2), 1, 0, 0);
         if (k == 3) begin
            checks++; if (bus.count !== 3'd4 || bus.full !== 1'b1 || bus.overflowErr !== 1'b0)
               begin errors++; $display("FAIL fill got cnt=%0d full=%b ovf=%b want 4/1/0", bus.count, bus.full, bus.overflowErr); end
         end
      end
      checks++; if (bus.count !== 3'd4 || bus.full !== 1'b1 || bus.overflowErr !== 1'b1)
         begin errors++; $display("FAIL overflow got cnt=%0d full=%b ovf=%b want 4/1/1", bus.count, bus.full, bus.overflowErr); end
      checks++; if (bus.flagsOut !== 4'b0110) begin errors++; $display("FAIL overflow_load got %b want 0110", bus.flagsOut); end
      for (int k = 0; k < 4; k++) begin
         tick(0, 1, 4'h0, 4'h0, 0, 1, 0);
         checks++; if (bus.flagsOut !== 4'(4 - k))
            begin errors++; $display("FAIL lifo_%0d got %b want %b", k, bus.flagsOut, 4'(4 - k)); end
      end
      checks++; if (bus.empty !== 1'b1 || bus.full !== 1'b0 || bus.count !== 3'd0 || bus.overflowErr !== 1'b1)
         begin errors++; $display("FAIL drained got e=%b f=%b c=%0d ovf=%b want 1/0/0/1", bus.empty, bus.full, bus.count, bus.overflowErr); end
   endtask

   task automatic test_underflow();
      tick(1, 1, 4'h0, 4'h0, 0, 0, 0);
      tick(0, 0, 4'b1000, 4'b1000, 0, 1, 0);
      checks++; if (bus.underflowErr !== 1'b1 || bus.flagsOut[FLAG_V] !== 1'b1 || bus.count !== 3'd0)
         begin errors++; $display("FAIL underflow got udf=%b v=%b c=%0d want 1/1/0", bus.underflowErr, bus.flagsOut[FLAG_V], bus.count); end
      tick(0, 1, 4'h0, 4'h0, 0, 1, 1);
      checks++; if (bus.underflowErr !== 1'b1) begin errors++; $display("FAIL clear_vs_event got %b want 1", bus.underflowErr); end
      tick(0, 1, 4'h0, 4'h0, 0, 0, 1);
      checks++; if (bus.underflowErr !== 1'b0) begin errors++; $display("FAIL err_clear got %b want 0", bus.underflowErr); end
   endtask

   task automatic test_swap();
      tick(1, 1, 4'h0, 4'h0, 0, 0, 0);
      tick(0, 0, 4'b1111, 4'b0011, 0, 0, 0);
      tick(0, 1, 4'h0, 4'h0, 1, 0, 0);
      tick(0, 0, 4'b1111, 4'b1100, 0, 0, 0);
      tick(0, 0, 4'b1111, 4'b0110, 1, 1, 0);
      checks++; if (bus.flagsOut !== 4'b0011 || bus.count !== 3'd1)
         begin errors++; $display("FAIL swap got %b/%0d want 0011/1", bus.flagsOut, bus.count); end
      tick(0, 1, 4'h0, 4'h0, 0, 1, 0);
      checks++; if (bus.flagsOut !== 4'b1100) begin errors++; $display("FAIL swap_top got %b want 1100", bus.flagsOut); end
      tick(0, 0, 4'b0001, 4'b0001, 1, 1, 0);
      checks++; if (bus.underflowErr !== 1'b1 || bus.overflowErr !== 1'b0 || bus.count !== 3'd1 || bus.flagsOut !== 4'b1101)
         begin errors++; $display("FAIL swap_empty got udf=%b ovf=%b c=%0d f=%b want 1/0/1/1101",
                                  bus.underflowErr, bus.overflowErr, bus.count, bus.flagsOut); end
      tick(0, 1, 4'h0, 4'h0, 0, 1, 0);
      checks++; if (bus.flagsOut !== 4'b1100) begin errors++; $display("FAIL swap_empty_saved got %b want 1100", bus.flagsOut); end
   endtask

   task automatic test_reset_mid();
      tick(1, 1, 4'h0, 4'h0, 0, 0, 0);
      tick(0, 1, 4'h0, 4'h0, 0, 1, 0);
      for (int k = 0; k < 3; k++) tick(0, 0, 4'b1111, 4'(k + 7), 1, 0, 0);
      checks++; if (bus.count !== 3'd3) begin errors++; $display("FAIL mid_count got %0d want 3", bus.count); end
      tick(1, 0, 4'b1111, 4'b1111, 1, 0, 0);
      checks++; if (bus.flagsOut !== 4'b0000 || bus.count !== 3'd0 || bus.underflowErr !== 1'b0 || bus.overflowErr !== 1'b0)
         begin errors++; $display("FAIL reset_mid got f=%b c=%0d udf=%b ovf=%b want 0/0/0/0",
                                  bus.flagsOut, bus.count, bus.underflowErr, bus.overflowErr); end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         tick(($urandom_range(0, 49) == 0), 1'($urandom), 4'($urandom), 4'($urandom),
              1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0));
         checks++; if (bus.flagsOut !== m_flags)
            begin errors++; $display("FAIL rnd_flags@%0d got %b want %b", n, bus.flagsOut, m_flags); end
         checks++; if (bus.count !== 3'(m_stack.size()))
            begin errors++; $display("FAIL rnd_count@%0d got %0d want %0d", n, bus.count, m_stack.size()); end
         checks++; if (bus.full !== (m_stack.size() == DP) || bus.empty !== (m_stack.size() == 0))
            begin errors++; $display("FAIL rnd_fe@%0d got %b%b want %b%b", n, bus.full, bus.empty,
                                     (m_stack.size() == DP), (m_stack.size() == 0)); end
         checks++; if (bus.overflowErr !== m_ovf || bus.underflowErr !== m_udf)
            begin errors++; $display("FAIL rnd_errs@%0d got %b%b want %b%b", n, bus.overflowErr, bus.underflowErr, m_ovf, m_udf); end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      bus.notLoad = 1'b1; bus.loadMask = '0; bus.flagsIn = '0;
      bus.push = 1'b0; bus.pop = 1'b0; bus.errClear = 1'b0;
      m_flags = '0; m_ovf = 1'b0; m_udf = 1'b0;
      #2;
      test_reset();
      test_load_mask();
      test_push_pop();
      test_overflow();
      test_underflow();
      test_swap();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout reached at %0t", $time);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/status_stack_reg.md
Name: status_stack_reg

Overview:
- Parametrised successor to the two-flag (carry/zero) status register.
- Holds FLAG_W condition flags with per-flag load enables, plus a LIFO save/restore stack of DEPTH entries so interrupt entry/exit and nested calls can push and pop the flag word.
- Sits between the ALU flag outputs and the control unit's branch/condition logic.
- Bit 0 = Z and bit 1 = C keep the existing flag layout.

Parameters:
- FLAG_W, 4, number of flags; bit0 Z, bit1 C, bit2 N, bit3 V; bits above 3 are general-purpose.
- DEPTH, 4, number of stack entries; must be at least 1.
- CNT_W, $clog2(DEPTH+1), width of the occupancy count (derived, not overridden).

Ports:
- clock  in  1  single system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- notLoad  in  1  active-low flag load strobe.
- loadMask  in  FLAG_W  per-flag load enable; used only while notLoad=0.
- flagsIn  in  FLAG_W  new flag values from the ALU.
- flagsOut  out  FLAG_W  current flag register.
- push  in  1  save current flags onto the stack.
- pop  in  1  restore flags from the top of the stack.
- errClear  in  1  clears the sticky error bits.
- count  out  CNT_W  number of stacked entries.
- full  out  1  count==DEPTH.
- empty  out  1  count==0.
- overflowErr  out  1  sticky: push attempted while full.
- underflowErr  out  1  sticky: pop attempted while empty.

Behaviour:
- Reset (reset=1 at a clock edge):
  - flagsOut=0, count=0, empty=1, full=0, overflowErr=0, underflowErr=0.
  - Stack contents are don't-care.
  - Reset overrides every other input in the same cycle.
- All outputs come straight from registers or from count compares. There is no combinational path from inputs to outputs. Effects are visible one cycle after the edge that samples them.
- Load: when notLoad=0, for each bit i with loadMask[i]=1, flagsOut[i] takes flagsIn[i]. Unmasked bits hold. When notLoad=1, loadMask is ignored.
- Push only (push=1, pop=0):
  - Not full: stack[count] takes the pre-edge flagsOut, and count increments.
  - Full: overflowErr is set and stack/count are unchanged.
  - In both cases any load applies normally. A push saves the old flags and the load updates the live ones.
- Pop only (pop=1, push=0):
  - Not empty: flagsOut takes stack[count-1], count decrements, and any load that cycle is ignored.
  - Empty: underflowErr is set, count is unchanged, and the load applies normally.
- Push and pop together:
  - Not empty: swap. flagsOut takes stack[count-1], stack[count-1] takes the pre-edge flagsOut, count is unchanged, and the load is ignored.
  - Empty: underflowErr is set and the operation behaves as a push-only (the entry is stored, count becomes 1, load applies). overflowErr is never set in this case.
- Sticky errors:
  - errClear=1 clears both error bits.
  - A new error event in the same cycle wins, so that bit stays 1.
- Wrap-around: none. count saturates within 0..DEPTH and the pointer never wraps.
- DEPTH=1: full and empty are mutually exclusive. Swap is legal while full.

Decomposition:
- Shared defines header (status_defs.v):
  - flag bit indices FLAG_Z=0, FLAG_C=1, FLAG_N=2, FLAG_V=3;
  - default FLAG_W.
- One sub-module, flag_stack_mem. It is a DEPTH x FLAG_W register array with write index/enable and a registered-free read of the top entry.
- Count, pointer, error and priority logic stay in status_stack_reg.

Test Plan:
- Reset, then notLoad=0, loadMask=4'b0011, flagsIn=4'b1110 -> flagsOut=4'b0010, count=0, empty=1.
- Set flags=4'b0101, then push. Next cycle load flags=4'b1010 with mask 4'b1111, then pop -> flagsOut=4'b0101, count=0.
- With DEPTH=4, push 5 times with distinct flag values -> count=4, full=1, overflowErr=1 after the 5th. Pop 4 times -> values come back in reverse order, empty=1.
- Pop while empty with notLoad=0, flagsIn=4'b1000, mask=4'b1000 -> underflowErr=1, flagsOut[3]=1, count=0. Then errClear -> underflowErr=0.
- Stack top=4'b0011, flags=4'b1100, push and pop in the same cycle -> flagsOut=4'b0011, top=4'b1100, count unchanged.
- Assert reset mid-sequence with count=3, push=1, notLoad=0 -> next cycle flagsOut=0, count=0, errors=0.
